// File: rtl/if_stage_ibuf.sv
// Instruction fetch stage with pipelined SRAM-like requests and an instruction buffer.
// Up to MAX_OUTST requests stay in flight; returned words queue for decode; taken branches squash.
module if_stage_ibuf #(
    parameter logic [31:0] RESET_PC   = 32'h1C00_0000,
    parameter int unsigned IBUF_DEPTH = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        ds_allowin,
    input  logic [32:0] br_zip,
    output logic        fs2ds_valid,
    output logic [63:0] fs2ds_bus
);

    localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PW = $clog2(IBUF_DEPTH);
    localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;
    localparam logic [OW-1:0] MAX_O    = OW'(MAX_OUTST);
    localparam logic [SW-1:0] DEPTH_S  = SW'(IBUF_DEPTH);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTST - 1);

    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] fetch_pc;
    logic [31:0] redir_pc;
    logic        redir_pending;
    logic        req_hold;
    logic        fetch_en;
    logic [OW-1:0] outst;
    logic [OW-1:0] discard;
    logic [OW-1:0] live;
    logic [OW-1:0] outst_next;
    logic [CW-1:0] ibuf_cnt;
    logic [PW-1:0] ibuf_rd;
    logic [PW-1:0] ibuf_wr;
    logic [63:0]   ibuf_mem [IBUF_DEPTH];
    logic [31:0]   tag_mem  [MAX_OUTST];
    logic [TW-1:0] tag_rd;
    logic [TW-1:0] tag_wr;
    logic [SW-1:0] fill;
    logic          accept;
    logic          ret;
    logic          drop;
    logic          push;
    logic          pop;

    assign br_taken  = br_zip[32];
    assign br_target = br_zip[31:0];

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = '0;
    assign inst_sram_wdata = '0;
    assign inst_sram_addr  = fetch_pc;

    // A request already presented but not yet accepted is held regardless of space.
    always_comb begin
        live          = outst - discard;
        fill          = SW'(ibuf_cnt) + SW'(live);
        inst_sram_req = fetch_en & (req_hold | ((outst < MAX_O) & (fill < DEPTH_S)));
        accept        = inst_sram_req & inst_sram_addr_ok;
        ret           = inst_sram_data_ok;
        drop          = ret & (discard != '0);
        outst_next    = outst + OW'(accept) - OW'(ret);
        fs2ds_valid   = (ibuf_cnt != '0) & ~br_taken;
        pop           = fs2ds_valid & ds_allowin;
        push          = ret & ~drop & ~br_taken;
        fs2ds_bus     = (ibuf_cnt != '0) ? ibuf_mem[ibuf_rd] : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc      <= RESET_PC;
            redir_pc      <= '0;
            redir_pending <= 1'b0;
            req_hold      <= 1'b0;
            fetch_en      <= 1'b0;
            outst         <= '0;
            discard       <= '0;
            ibuf_cnt      <= '0;
            ibuf_rd       <= '0;
            ibuf_wr       <= '0;
            tag_rd        <= '0;
            tag_wr        <= '0;
        end else begin
            fetch_en <= 1'b1;
            outst    <= outst_next;
            req_hold <= inst_sram_req & ~inst_sram_addr_ok;
            if (accept) tag_wr <= (tag_wr == TAG_LAST) ? '0 : tag_wr + 1'b1;
            if (ret)    tag_rd <= (tag_rd == TAG_LAST) ? '0 : tag_rd + 1'b1;

            if (br_taken) begin
                // Everything still in flight after this edge is stale.
                discard  <= outst_next;
                ibuf_cnt <= '0;
                ibuf_rd  <= ibuf_wr;
                if (inst_sram_req & ~inst_sram_addr_ok) begin
                    redir_pending <= 1'b1;
                    redir_pc      <= br_target;
                end else begin
                    redir_pending <= 1'b0;
                    fetch_pc      <= br_target;
                end
            end else begin
                discard  <= discard - OW'(drop) + OW'(accept & redir_pending);
                ibuf_cnt <= ibuf_cnt + CW'(push) - CW'(pop);
                if (push) ibuf_wr <= ibuf_wr + 1'b1;
                if (pop)  ibuf_rd <= ibuf_rd + 1'b1;
                if (accept) begin
                    fetch_pc      <= redir_pending ? redir_pc : fetch_pc + 32'd4;
                    redir_pending <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_mem[tag_wr] <= fetch_pc;
        if (push)   ibuf_mem[ibuf_wr] <= {inst_sram_rdata, tag_mem[tag_rd]};
    end

`ifndef SYNTHESIS
    data_ok_needs_outst: assert property (@(posedge clk) disable iff (!resetn)
        inst_sram_data_ok |-> (outst != '0));
`endif

endmodule

// File: tb/tb_if_stage_ibuf.sv
// Self-checking bench for if_stage_ibuf: in-order memory model plus a pc/inst scoreboard.
module tb_if_stage_ibuf;

    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    logic        clk;
    logic        resetn = 1'b1;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        ds_allowin;
    logic [32:0] br_zip;
    logic        fs2ds_valid;
    logic [63:0] fs2ds_bus;

    if_stage_ibuf #(.RESET_PC(RESET_PC), .IBUF_DEPTH(4), .MAX_OUTST(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin), .br_zip(br_zip),
        .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned ready;
    } mreq_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned pop_cnt  = 0;
    int unsigned acc_cnt  = 0;
    int unsigned cyc      = 0;
    int unsigned lat      = 1;
    bit          stall    = 0;
    bit          aok_rand = 0;
    logic [63:0] exp_q[$];
    mreq_t       memq[$];
    logic [31:0] next_addr   = RESET_PC;
    logic [31:0] redir_tgt   = '0;
    logic [31:0] prev_addr   = '0;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] last_acc    = '0;
    bit          prev_held   = 0;
    bit          squash_next = 0;
    bit          redir_valid = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // In-order memory: accepted requests return after 'lat' cycles or more.
    initial begin
        mreq_t m;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                memq.delete();
            end else begin
                if (inst_sram_data_ok && memq.size() != 0) m = memq.pop_front();
                if (inst_sram_req && inst_sram_addr_ok)
                    memq.push_back('{addr: inst_sram_addr, ready: cyc + lat});
            end
            @(posedge clk);
            cyc++;
            #2;
            inst_sram_addr_ok = stall ? 1'b0 : (aok_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            if (resetn && memq.size() != 0 && memq[0].ready <= cyc) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = inst_of(memq[0].addr);
            end else begin
                inst_sram_data_ok = 1'b0;
                inst_sram_rdata   = $urandom;
            end
        end
    end

    // Monitor and scoreboard: expected {inst, pc} pushed at accept, compared at pop.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_held = 0;
            end else begin
                if (prev_held) begin
                    chk("req_hold", inst_sram_req, 1'b1);
                    chk("addr_hold", inst_sram_addr, prev_addr);
                end
                if (br_zip[32]) chk("valid_on_br", fs2ds_valid, 1'b0);
                if (fs2ds_valid && ds_allowin) begin
                    if (exp_q.size() == 0) chk("pop_unexpected", fs2ds_valid, 1'b0);
                    else                   chk("bus", fs2ds_bus, exp_q.pop_front());
                    last_pop_pc = fs2ds_bus[31:0];
                    pop_cnt++;
                end
                if (inst_sram_req && inst_sram_addr_ok) begin
                    chk("addr", inst_sram_addr, next_addr);
                    last_acc = inst_sram_addr;
                    acc_cnt++;
                    if (squash_next) squash_next = 0;
                    else exp_q.push_back({inst_of(inst_sram_addr), inst_sram_addr});
                    if (redir_valid) begin
                        next_addr   = redir_tgt;
                        redir_valid = 0;
                    end else begin
                        next_addr = next_addr + 32'd4;
                    end
                end
                if (br_zip[32]) begin
                    exp_q.delete();
                    if (inst_sram_req && !inst_sram_addr_ok) begin
                        squash_next = 1;
                        redir_valid = 1;
                        redir_tgt   = br_zip[31:0];
                    end else begin
                        next_addr   = br_zip[31:0];
                        redir_valid = 0;
                    end
                end
                prev_held = inst_sram_req && !inst_sram_addr_ok;
                prev_addr = inst_sram_addr;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        br_zip = '0;
        #1;
        chk("rst_req", inst_sram_req, 1'b0);
        chk("rst_valid", fs2ds_valid, 1'b0);
        chk("rst_bus", fs2ds_bus, 64'd0);
        exp_q.delete();
        next_addr = RESET_PC; redir_valid = 0; squash_next = 0; acc_cnt = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic wait_pops(input int unsigned target, input string tag);
        for (int i = 0; i < 60 && pop_cnt < target; i++) begin @(negedge clk); #1; end
        chk(tag, pop_cnt, target);
    endtask

    task automatic wait_acc(input int unsigned target, input string tag);
        for (int i = 0; i < 60 && acc_cnt < target; i++) begin @(negedge clk); #1; end
        chk(tag, acc_cnt, target);
    endtask

    task automatic pulse_br(input logic [31:0] tgt, output int unsigned p0);
        @(posedge clk); #1;
        br_zip = {1'b1, tgt};
        p0 = pop_cnt;
        @(posedge clk); #1;
        br_zip = '0;
    endtask

    initial begin
        int unsigned p0;
        ds_allowin = 1'b1;
        br_zip     = '0;

        // Streaming fetch, no zero-cycle bypass, one instruction per cycle.
        lat = 1;
        do_reset();
        for (int i = 0; i < 20 && !inst_sram_data_ok; i++) begin @(negedge clk); #1; end
        chk("no_bypass", fs2ds_valid, 1'b0);
        chk("const_wr", inst_sram_wr, 1'b0);
        chk("const_size", inst_sram_size, 2'b10);
        chk("const_wstrb", inst_sram_wstrb, 4'd0);
        chk("const_wdata", inst_sram_wdata, 32'd0);
        repeat (4) @(posedge clk);
        #1 p0 = pop_cnt;
        repeat (8) @(posedge clk);
        #1 chk("throughput", pop_cnt - p0, 8);

        // Branch with data_ok and pop pending in the same cycle.
        pulse_br(32'h1C00_0300, p0);
        @(negedge clk); #1;
        chk("flush_empty", fs2ds_valid, 1'b0);
        wait_pops(p0 + 1, "br300_pop");
        chk("br300_pc", last_pop_pc, 32'h1C00_0300);

        // PC wrap-around modulo 2^32.
        pulse_br(32'hFFFF_FFF8, p0);
        wait_pops(p0 + 3, "wrap_pop");
        chk("wrap_pc", last_pop_pc, 32'h0000_0000);

        // Asynchronous reset between clock edges.
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("async_req", inst_sram_req, 1'b0);
        chk("async_valid", fs2ds_valid, 1'b0);
        exp_q.delete();
        next_addr = RESET_PC; redir_valid = 0; squash_next = 0; acc_cnt = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        wait_acc(1, "post_rst_acc");
        chk("post_rst_addr", last_acc, RESET_PC);

        // Decode stalled: buffer fills to exactly IBUF_DEPTH, then drains in order.
        ds_allowin = 1'b0;
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        chk("stall_accepts", acc_cnt, 4);
        chk("stall_req", inst_sram_req, 1'b0);
        p0 = pop_cnt;
        ds_allowin = 1'b1;
        wait_pops(p0 + 4, "stall_drain");
        chk("stall_last_pc", last_pop_pc, 32'h1C00_000C);

        // Two requests in flight when the branch arrives.
        lat = 3;
        do_reset();
        wait_acc(2, "outst_acc");
        pulse_br(32'h1C00_0100, p0);
        wait_pops(p0 + 1, "br100_pop");
        chk("br100_pc", last_pop_pc, 32'h1C00_0100);

        // Branch while a request is held without addr_ok.
        lat = 1;
        do_reset();
        wait_acc(2, "hold_acc");
        @(posedge clk); #1;
        stall = 1;
        @(posedge clk); #1;
        chk("held_addr", inst_sram_addr, 32'h1C00_0008);
        br_zip = {1'b1, 32'h1C00_0200};
        p0 = pop_cnt;
        @(posedge clk); #1;
        br_zip = '0;
        repeat (2) @(posedge clk);
        #1 stall = 0;
        wait_pops(p0 + 1, "br200_pop");
        chk("br200_pc", last_pop_pc, 32'h1C00_0200);

        // Random traffic: stalls on both sides, variable latency, random branches.
        aok_rand = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            ds_allowin = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 4);
            if (br_zip[32])                        br_zip = '0;
            else if ($urandom_range(0, 15) == 0)   br_zip = {1'b1, RESET_PC + 32'($urandom_range(0, 255)) * 32'd4};
        end
        @(posedge clk); #1;
        br_zip = '0; aok_rand = 0; ds_allowin = 1'b1; lat = 1;
        p0 = pop_cnt;
        repeat (20) @(posedge clk);
        #1 chk("drain_flow", 1'(pop_cnt - p0 >= 10), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_stage_ibuf.md
Name: if_stage_ibuf

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Talks to instruction memory over the split-transaction SRAM-like interface: req/addr_ok accepts a request, data_ok returns data in order.
- Keeps up to MAX_OUTST requests in flight and queues returned instructions in an IBUF_DEPTH-entry buffer, decoupling memory latency from decode stalls.
- Squashes in-flight and buffered instructions on a taken branch from decode.

Parameters:
RESET_PC, 32'h1C00_0000, address of first fetch after reset
IBUF_DEPTH, 4, instruction buffer entries (power of 2, >=2)
MAX_OUTST, 2, max accepted-but-unreturned requests (>=1)

Ports:
clk  in  1  clock; all state on rising edge
resetn  in  1  asynchronous active-low reset; one clock domain
inst_sram_req  out  1  fetch request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10 (word)
inst_sram_wstrb  out  4  constant 0
inst_sram_addr  out  32  fetch address (= fetch_pc)
inst_sram_wdata  out  32  constant 0
inst_sram_addr_ok  in  1  request accepted this cycle when req=1
inst_sram_data_ok  in  1  in-order read data valid
inst_sram_rdata  in  32  read data
ds_allowin  in  1  decode can accept
br_zip  in  33  {br_taken, br_target}; br_taken is a single-cycle pulse
fs2ds_valid  out  1  instruction available to decode
fs2ds_bus  out  64  {inst[31:0], pc[31:0]} of ibuf head

Behaviour:
- Reset (async, resetn=0) values:
  - fetch_pc=RESET_PC; outst=0, discard=0, ibuf count=0, redir_pending=0.
  - req=0, fs2ds_valid=0, fs2ds_bus=0, as seen at the outputs immediately.
- Live in-flight count: live = outst - discard.
- Request issue:
  - Condition: req = ~req_hold_blocked & (outst < MAX_OUTST) & (ibuf_count + live < IBUF_DEPTH).
  - Once req=1 with addr_ok=0, req and addr stay stable until addr_ok. They are never withdrawn or changed, including on a branch.
- Accept (req & addr_ok):
  - Push fetch_pc into the pc tag queue (depth MAX_OUTST); outst++.
  - fetch_pc <= redir_pending ? redir_pc : fetch_pc+4; redir_pending cleared.
- Return (data_ok):
  - Pop pc tag; outst--.
  - If discard>0: drop the data, discard--.
  - Else: push {rdata, tag_pc} into ibuf.
  - data_ok with outst=0 is a protocol error (assertion).
- Output:
  - fs2ds_valid = (ibuf_count!=0) & ~br_taken.
  - Head pops when fs2ds_valid & ds_allowin.
  - Zero-cycle bypass from rdata to decode is not permitted. Latency: data_ok in cycle N -> fs2ds_valid in cycle N+1.
- Taken branch (br_taken=1):
  - ibuf flushed (count<=0; same-cycle push and pop suppressed).
  - discard <= outst_next, where outst_next includes any request accepted this cycle and excludes any data_ok consumed this cycle.
  - If a request is held (req & ~addr_ok): redir_pending<=1, redir_pc<=br_target; that request counts as one extra discard when accepted.
  - Otherwise fetch_pc <= br_target.
- Simultaneous events:
  - accept+return same cycle: outst unchanged; tag queue pushes and pops.
  - ibuf push+pop with full buffer is legal; net count unchanged.
  - A second branch before all discards drain recomputes discard per the rule above.
- Arithmetic:
  - pc +4 wraps modulo 2^32.
  - Counters are $clog2 sized to hold IBUF_DEPTH / MAX_OUTST inclusive.
  - Ibuf and tag queue are circular with wrap-around pointers.
- Reset mid-operation: all in-flight data_ok after reset release is not expected. Memory is reset together with the core.

Test Plan:
- Reset release, addr_ok=1, data_ok 1 cycle after accept, ds_allowin=1 -> addrs 0x1C000000, 0x1C000004, 0x1C000008…; fs2ds_bus pc matches, inst=rdata, one instr/cycle steady state.
- ds_allowin=0 after reset, memory always ready -> exactly IBUF_DEPTH requests issued then req=0. On ds_allowin=1, 4 instrs emerge in order with pcs 0x1C000000..0x1C00000C, with no loss or duplication.
- Two requests outstanding (pc 0x1C000010, 0x1C000014), br_taken with target 0x1C000100 -> both data_ok dropped; next accepted addr 0x1C000100; next fs2ds pc=0x1C000100.
- req held at 0x1C000008 with addr_ok=0 when br_taken to 0x1C000200 -> addr stays 0x1C000008 until addr_ok; its data is dropped; following request addr 0x1C000200.
- br_taken in the same cycle as data_ok and ds_allowin with ibuf non-empty -> fs2ds_valid=0 that cycle, ibuf empty next cycle, returned data not buffered.
- resetn asserted low asynchronously mid-stream (between edges) -> req, fs2ds_valid drop to 0 before next edge. After release, first addr=0x1C000000.
